// File: rtl/vxe_cu_pkg.sv
// Shared VxE control-unit definitions: command word layout, opcodes,
// dispatch FSM state encoding and decode classes.
package vxe_cu_pkg;

    localparam int unsigned ADDR_W = 37;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned TH_W   = 3;
    localparam int unsigned PL_W   = 48;
    localparam int unsigned CLS_W  = 3;

    // Command word field positions
    localparam int unsigned OP_HI   = 63;
    localparam int unsigned OP_LO   = 59;
    localparam int unsigned TH_HI   = 58;
    localparam int unsigned TH_LO   = 56;
    localparam int unsigned UNI_BIT = 55;
    localparam int unsigned RSV_HI  = 54;
    localparam int unsigned RSV_LO  = 49;
    localparam int unsigned SEL_BIT = 48;

    localparam logic [OP_W-1:0] OP_NOP     = 5'h00;
    localparam logic [OP_W-1:0] OP_SYNC    = 5'h01;
    localparam logic [OP_W-1:0] OP_VPU_MIN = 5'h08;

    // Forwarded command payload held in the stage register
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [TH_W-1:0] th;
        logic            uni;
        logic            sel;
        logic [PL_W-1:0] pl;
    } fwd_cmd_t;

    localparam int unsigned FWD_W = OP_W + TH_W + 2 + PL_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FWD   = 2'd1,
        ST_WSYNC = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [CLS_W-1:0] {
        CLS_VPU       = 3'd0,
        CLS_NOP       = 3'd1,
        CLS_SYNC      = 3'd2,
        CLS_ILLEGAL   = 3'd3,
        CLS_FETCH_ERR = 3'd4
    } cls_e;

endpackage

// File: rtl/vxe_cu_dispatch_decode.sv
// Combinational classification and field extraction of the head command.
// Optional macro VXE_CU_DISPATCH_STRICT_DECODE_EN: reserved bits [54:49],
// or the VPU select bit on a broadcast, turn the command into a decode fault.
module vxe_cu_dispatch_decode
    import vxe_cu_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic              err,
    output logic [CLS_W-1:0]  cls,
    output logic [FWD_W-1:0]  cmd
);

    logic [OP_W-1:0] op;
    logic            rsvd_viol;
    cls_e            cls_d;
    fwd_cmd_t        cmd_d;

    assign op = data[OP_HI:OP_LO];

`ifdef VXE_CU_DISPATCH_STRICT_DECODE_EN
    assign rsvd_viol = (|data[RSV_HI:RSV_LO]) | (!data[UNI_BIT] & data[SEL_BIT]);
`else
    logic unused_rsvd;
    assign unused_rsvd = ^data[RSV_HI:RSV_LO];
    assign rsvd_viol   = 1'b0;
`endif

    // Classify: fetch error wins over any decode outcome
    always_comb begin
        cls_d = CLS_VPU;
        if (err) begin
            cls_d = CLS_FETCH_ERR;
        end else if (rsvd_viol) begin
            cls_d = CLS_ILLEGAL;
        end else if (op == OP_NOP) begin
            cls_d = CLS_NOP;
        end else if (op == OP_SYNC) begin
            cls_d = CLS_SYNC;
        end else if (op < OP_VPU_MIN) begin
            cls_d = CLS_ILLEGAL;
        end
    end

    // Field extraction for the stage register
    always_comb begin
        cmd_d     = '0;
        cmd_d.op  = op;
        cmd_d.th  = data[TH_HI:TH_LO];
        cmd_d.uni = data[UNI_BIT];
        cmd_d.sel = data[SEL_BIT];
        cmd_d.pl  = data[PL_W-1:0];
    end

    assign cls = cls_d;
    assign cmd = cmd_d;

endmodule

// File: rtl/vxe_cu_dispatch.sv
// VxE CU command dispatch: pops commands from fetch, forwards VPU commands
// to VPU0/VPU1 through a one-entry stage, raises NOP/SYNC events and
// fetch/decode faults, and stalls in HALT until unhalted.
// Optional macro VXE_CU_DISPATCH_STRICT_DECODE_EN (see decode sub-module).
module vxe_cu_dispatch
    import vxe_cu_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    input  logic [WORD_W-1:0] i_fetch_data,
    input  logic              i_fetch_vld,
    input  logic              i_fetch_err,
    output logic              o_fetch_rd,
    output logic              o_flt_fetch,
    output logic              o_flt_decode,
    output logic [ADDR_W-1:0] o_flt_fetch_addr,
    output logic [ADDR_W-1:0] o_flt_decode_addr,
    output logic [WORD_W-1:0] o_flt_decode_data,
    output logic              o_ctl_nop,
    output logic              o_ctl_sync,
    output logic              o_ctl_sync_stop,
    output logic              o_ctl_sync_intr,
    output logic              o_ctl_pipes_active,
    input  logic              i_ctl_halt,
    input  logic              i_ctl_unhalt,
    input  logic              i_fwd_vpu0_rdy,
    output logic [OP_W-1:0]   o_fwd_vpu0_op,
    output logic [TH_W-1:0]   o_fwd_vpu0_th,
    output logic [PL_W-1:0]   o_fwd_vpu0_pl,
    output logic              o_fwd_vpu0_wr,
    input  logic              i_fwd_vpu1_rdy,
    output logic [OP_W-1:0]   o_fwd_vpu1_op,
    output logic [TH_W-1:0]   o_fwd_vpu1_th,
    output logic [PL_W-1:0]   o_fwd_vpu1_pl,
    output logic              o_fwd_vpu1_wr
);

    state_e           state_q, state_d;
    fwd_cmd_t         stage_q;
    logic             halt_pend_q, halt_pend_d;
    logic             sync_stop_q, sync_intr_q;
    logic [CLS_W-1:0] dec_cls;
    logic [FWD_W-1:0] dec_cmd;

    logic stage_full_c, wr0_c, wr1_c, fwd_done_c, halt_req_c, accept_c;
    logic pop_c, load_c, flt_fetch_c, flt_dec_c, nop_c, sync_latch_c, sync_fire_c;

    vxe_cu_dispatch_decode u_decode (
        .data (i_fetch_data),
        .err  (i_fetch_err),
        .cls  (dec_cls),
        .cmd  (dec_cmd)
    );

    // Write strobes follow the stage and the VPU ready handshake
    assign stage_full_c = (state_q == ST_FWD);
    assign wr0_c = stage_full_c & (stage_q.uni ? (!stage_q.sel & i_fwd_vpu0_rdy)
                                               : (i_fwd_vpu0_rdy & i_fwd_vpu1_rdy));
    assign wr1_c = stage_full_c & (stage_q.uni ? (stage_q.sel & i_fwd_vpu1_rdy)
                                               : (i_fwd_vpu0_rdy & i_fwd_vpu1_rdy));
    assign fwd_done_c = wr0_c | wr1_c;
    assign halt_req_c = i_ctl_halt | halt_pend_q;

    assign o_fwd_vpu0_wr      = wr0_c;
    assign o_fwd_vpu1_wr      = wr1_c;
    assign o_fwd_vpu0_op      = stage_q.op;
    assign o_fwd_vpu0_th      = stage_q.th;
    assign o_fwd_vpu0_pl      = stage_q.pl;
    assign o_fwd_vpu1_op      = stage_q.op;
    assign o_fwd_vpu1_th      = stage_q.th;
    assign o_fwd_vpu1_pl      = stage_q.pl;
    assign o_ctl_pipes_active = stage_full_c | !i_fwd_vpu0_rdy | !i_fwd_vpu1_rdy;
    assign o_fetch_rd         = pop_c;

    // Next-state and pop/decode actions
    always_comb begin
        state_d      = state_q;
        halt_pend_d  = 1'b0;
        accept_c     = 1'b0;
        pop_c        = 1'b0;
        load_c       = 1'b0;
        flt_fetch_c  = 1'b0;
        flt_dec_c    = 1'b0;
        nop_c        = 1'b0;
        sync_latch_c = 1'b0;
        sync_fire_c  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (halt_req_c) state_d = ST_HALT;
                else            accept_c = 1'b1;
            end
            ST_FWD: begin
                if (!fwd_done_c) begin
                    halt_pend_d = halt_req_c;
                end else if (halt_req_c) begin
                    state_d = ST_HALT;
                end else begin
                    state_d  = ST_RUN;
                    accept_c = 1'b1;
                end
            end
            ST_WSYNC: begin
                if (!o_ctl_pipes_active) begin
                    sync_fire_c = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_ctl_unhalt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        if (accept_c && i_fetch_vld) begin
            pop_c = 1'b1;
            case (cls_e'(dec_cls))
                CLS_FETCH_ERR: begin flt_fetch_c = 1'b1; state_d = ST_HALT; end
                CLS_ILLEGAL:   begin flt_dec_c   = 1'b1; state_d = ST_HALT; end
                CLS_NOP:       begin nop_c       = 1'b1; state_d = ST_HALT; end
                CLS_SYNC:      begin sync_latch_c = 1'b1; state_d = ST_WSYNC; end
                default:       begin load_c      = 1'b1; state_d = ST_FWD; end
            endcase
        end
    end

    // FSM state, stage register and pending SYNC flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_RUN;
            halt_pend_q <= 1'b0;
            stage_q     <= '0;
            sync_stop_q <= 1'b0;
            sync_intr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            if (load_c) stage_q <= fwd_cmd_t'(dec_cmd);
            if (sync_latch_c) begin
                sync_stop_q <= i_fetch_data[0];
                sync_intr_q <= i_fetch_data[1];
            end
        end
    end

    // Registered event pulses and held fault capture
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_flt_fetch       <= 1'b0;
            o_flt_decode      <= 1'b0;
            o_flt_fetch_addr  <= '0;
            o_flt_decode_addr <= '0;
            o_flt_decode_data <= '0;
            o_ctl_nop         <= 1'b0;
            o_ctl_sync        <= 1'b0;
            o_ctl_sync_stop   <= 1'b0;
            o_ctl_sync_intr   <= 1'b0;
        end else begin
            o_flt_fetch     <= flt_fetch_c;
            o_flt_decode    <= flt_dec_c;
            o_ctl_nop       <= nop_c;
            o_ctl_sync      <= sync_fire_c;
            o_ctl_sync_stop <= sync_fire_c & sync_stop_q;
            o_ctl_sync_intr <= sync_fire_c & sync_intr_q;
            if (flt_fetch_c) o_flt_fetch_addr <= i_fetch_addr;
            if (flt_dec_c) begin
                o_flt_decode_addr <= i_fetch_addr;
                o_flt_decode_data <= i_fetch_data;
            end
        end
    end

endmodule

// File: tb/tb_vxe_cu_dispatch.sv
// Scoreboard bench for vxe_cu_dispatch: directed commands are queued in a
// fetch model, expected responses are queued alongside, and a monitor pops
// and compares on every DUT output event.
module tb_vxe_cu_dispatch;

    logic        clk = 1'b0;
    logic        nrst;
    logic [36:0] i_fetch_addr;
    logic [63:0] i_fetch_data;
    logic        i_fetch_vld;
    logic        i_fetch_err;
    logic        o_fetch_rd;
    logic        o_flt_fetch, o_flt_decode;
    logic [36:0] o_flt_fetch_addr, o_flt_decode_addr;
    logic [63:0] o_flt_decode_data;
    logic        o_ctl_nop, o_ctl_sync, o_ctl_sync_stop, o_ctl_sync_intr;
    logic        o_ctl_pipes_active;
    logic        i_ctl_halt, i_ctl_unhalt;
    logic        i_fwd_vpu0_rdy, i_fwd_vpu1_rdy;
    logic [4:0]  o_fwd_vpu0_op, o_fwd_vpu1_op;
    logic [2:0]  o_fwd_vpu0_th, o_fwd_vpu1_th;
    logic [47:0] o_fwd_vpu0_pl, o_fwd_vpu1_pl;
    logic        o_fwd_vpu0_wr, o_fwd_vpu1_wr;

    always #5 clk = ~clk;

    vxe_cu_dispatch dut (
        .clk                (clk),
        .nrst               (nrst),
        .i_fetch_addr       (i_fetch_addr),
        .i_fetch_data       (i_fetch_data),
        .i_fetch_vld        (i_fetch_vld),
        .i_fetch_err        (i_fetch_err),
        .o_fetch_rd         (o_fetch_rd),
        .o_flt_fetch        (o_flt_fetch),
        .o_flt_decode       (o_flt_decode),
        .o_flt_fetch_addr   (o_flt_fetch_addr),
        .o_flt_decode_addr  (o_flt_decode_addr),
        .o_flt_decode_data  (o_flt_decode_data),
        .o_ctl_nop          (o_ctl_nop),
        .o_ctl_sync         (o_ctl_sync),
        .o_ctl_sync_stop    (o_ctl_sync_stop),
        .o_ctl_sync_intr    (o_ctl_sync_intr),
        .o_ctl_pipes_active (o_ctl_pipes_active),
        .i_ctl_halt         (i_ctl_halt),
        .i_ctl_unhalt       (i_ctl_unhalt),
        .i_fwd_vpu0_rdy     (i_fwd_vpu0_rdy),
        .o_fwd_vpu0_op      (o_fwd_vpu0_op),
        .o_fwd_vpu0_th      (o_fwd_vpu0_th),
        .o_fwd_vpu0_pl      (o_fwd_vpu0_pl),
        .o_fwd_vpu0_wr      (o_fwd_vpu0_wr),
        .i_fwd_vpu1_rdy     (i_fwd_vpu1_rdy),
        .o_fwd_vpu1_op      (o_fwd_vpu1_op),
        .o_fwd_vpu1_th      (o_fwd_vpu1_th),
        .o_fwd_vpu1_pl      (o_fwd_vpu1_pl),
        .o_fwd_vpu1_wr      (o_fwd_vpu1_wr)
    );

    typedef struct packed {
        logic [36:0] addr;
        logic [63:0] data;
        logic        err;
    } fent_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  th;
        logic [47:0] pl;
        logic        bc;
    } fexp_t;

    typedef struct packed {
        logic [36:0] a;
        logic [63:0] d;
    } dexp_t;

    fent_t       fq[$];
    fexp_t       q0[$];
    fexp_t       q1[$];
    logic [1:0]  sync_q[$];
    logic [36:0] ff_q[$];
    dexp_t       dq[$];
    int          nop_pend = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic        rd_s;

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [2:0] th,
                                       input logic uni, input logic sel,
                                       input logic [47:0] pl);
        return {op, th, uni, 6'b0, sel, pl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [36:0] a, input logic [63:0] d, input logic e);
        fq.push_back(fent_t'{addr: a, data: d, err: e});
    endtask

    // port: 0 = VPU0, 1 = VPU1, 2 = broadcast
    task automatic exp_fwd(input int port, input logic [4:0] op, input logic [2:0] th,
                           input logic [47:0] pl);
        fexp_t e;
        e = fexp_t'{op: op, th: th, pl: pl, bc: (port == 2)};
        if (port != 1) q0.push_back(e);
        if (port != 0) q1.push_back(e);
    endtask

    // mode: 0 = everything, 1 = control/fault only, 2 = forwards only
    task automatic wait_drain(input string name, input int mode, input int budget);
        int n = 0;
        int pend;
        forever begin
            pend = 0;
            if (mode != 1) pend += q0.size() + q1.size();
            if (mode != 2) pend += nop_pend + sync_q.size() + ff_q.size() + dq.size();
            if (pend == 0 || n >= budget) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_pending"}, 64'(pend), 64'd0);
    endtask

    task automatic pulse_unhalt();
        i_ctl_unhalt = 1'b1;
        cyc(1);
        i_ctl_unhalt = 1'b0;
    endtask

    // Show-ahead fetch model: pops the head when the DUT read it
    initial begin
        i_fetch_vld  = 1'b0;
        i_fetch_err  = 1'b0;
        i_fetch_addr = '0;
        i_fetch_data = '0;
        forever begin
            @(negedge clk);
            rd_s = o_fetch_rd;
            @(posedge clk);
            #2;
            if (rd_s && fq.size() > 0) void'(fq.pop_front());
            if (fq.size() > 0) begin
                i_fetch_vld  = 1'b1;
                i_fetch_addr = fq[0].addr;
                i_fetch_data = fq[0].data;
                i_fetch_err  = fq[0].err;
            end else begin
                i_fetch_vld  = 1'b0;
                i_fetch_err  = 1'b0;
            end
        end
    end

    // Monitor: every output event pops and checks one expectation
    always @(negedge clk) begin
        fexp_t e;
        dexp_t d;
        logic [1:0] s;
        logic [36:0] a;
        if (nrst) begin
            if (o_fwd_vpu0_wr) begin
                chk("vpu0_wr_expected", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("vpu0_op", 64'(o_fwd_vpu0_op), 64'(e.op));
                    chk("vpu0_th", 64'(o_fwd_vpu0_th), 64'(e.th));
                    chk("vpu0_pl", 64'(o_fwd_vpu0_pl), 64'(e.pl));
                    if (e.bc) chk("bcast_pair_vpu1_wr", 64'(o_fwd_vpu1_wr), 64'd1);
                end
            end
            if (o_fwd_vpu1_wr) begin
                chk("vpu1_wr_expected", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("vpu1_op", 64'(o_fwd_vpu1_op), 64'(e.op));
                    chk("vpu1_th", 64'(o_fwd_vpu1_th), 64'(e.th));
                    chk("vpu1_pl", 64'(o_fwd_vpu1_pl), 64'(e.pl));
                    if (e.bc) chk("bcast_pair_vpu0_wr", 64'(o_fwd_vpu0_wr), 64'd1);
                end
            end
            if (o_ctl_nop) begin
                chk("nop_expected", 64'(nop_pend != 0), 64'd1);
                if (nop_pend != 0) nop_pend--;
            end
            if (o_ctl_sync) begin
                chk("sync_expected", 64'(sync_q.size() != 0), 64'd1);
                if (sync_q.size() != 0) begin
                    s = sync_q.pop_front();
                    chk("sync_flags", 64'({o_ctl_sync_stop, o_ctl_sync_intr}), 64'(s));
                end
            end
            if (o_flt_fetch) begin
                chk("flt_fetch_expected", 64'(ff_q.size() != 0), 64'd1);
                if (ff_q.size() != 0) begin
                    a = ff_q.pop_front();
                    chk("flt_fetch_addr", 64'(o_flt_fetch_addr), 64'(a));
                end
            end
            if (o_flt_decode) begin
                chk("flt_decode_expected", 64'(dq.size() != 0), 64'd1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    chk("flt_decode_addr", 64'(o_flt_decode_addr), 64'(d.a));
                    chk("flt_decode_data", o_flt_decode_data, d.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst           = 1'b0;
        i_ctl_halt     = 1'b0;
        i_ctl_unhalt   = 1'b0;
        i_fwd_vpu0_rdy = 1'b1;
        i_fwd_vpu1_rdy = 1'b1;
        cyc(2);

        // Reset state
        chk("rst_fetch_rd",     64'(o_fetch_rd), 64'd0);
        chk("rst_vpu0_wr",      64'(o_fwd_vpu0_wr), 64'd0);
        chk("rst_vpu1_wr",      64'(o_fwd_vpu1_wr), 64'd0);
        chk("rst_ctl_nop",      64'(o_ctl_nop), 64'd0);
        chk("rst_ctl_sync",     64'(o_ctl_sync), 64'd0);
        chk("rst_flt_fetch",    64'(o_flt_fetch), 64'd0);
        chk("rst_flt_decode",   64'(o_flt_decode), 64'd0);
        chk("rst_flt_dec_data", o_flt_decode_data, 64'd0);
        chk("rst_pipes_active", 64'(o_ctl_pipes_active), 64'd0);
        chk("rst_vpu0_pl",      64'(o_fwd_vpu0_pl), 64'd0);
        nrst = 1'b1;
        cyc(2);

        // NOP halts fetch until unhalt, then the next command issues
        push_cmd(37'h1, mk(5'h00, 3'd0, 1'b0, 1'b0, 48'h0), 1'b0);
        push_cmd(37'h2, mk(5'h09, 3'd1, 1'b1, 1'b0, 48'h1111), 1'b0);
        nop_pend = 1;
        exp_fwd(0, 5'h09, 3'd1, 48'h1111);
        wait_drain("nop", 1, 50);
        cyc(4);
        chk("nop_stall_fifo", 64'(fq.size()), 64'd1);
        chk("nop_stall_rd",   64'(o_fetch_rd), 64'd0);
        chk("nop_no_fwd",     64'(q0.size()), 64'd1);
        pulse_unhalt();
        wait_drain("nop_resume", 0, 50);

        // Fetch error on third entry; it is never forwarded
        push_cmd(37'h1, mk(5'h0A, 3'd3, 1'b0, 1'b0, 48'hA0A0), 1'b0);
        push_cmd(37'h2, mk(5'h0B, 3'd4, 1'b0, 1'b0, 48'hB0B0), 1'b0);
        push_cmd(37'h3, mk(5'h0C, 3'd5, 1'b0, 1'b0, 48'hC0C0), 1'b1);
        exp_fwd(2, 5'h0A, 3'd3, 48'hA0A0);
        exp_fwd(2, 5'h0B, 3'd4, 48'hB0B0);
        ff_q.push_back(37'h3);
        wait_drain("fetch_err", 0, 50);
        cyc(3);
        pulse_unhalt();

        // Illegal opcode 0x05 captured verbatim
        push_cmd(37'h10, 64'h2800_0000_0000_1234, 1'b0);
        dq.push_back(dexp_t'{a: 37'h10, d: 64'h2800_0000_0000_1234});
        wait_drain("decode_flt", 0, 50);
        cyc(3);
        pulse_unhalt();
        cyc(2);
        chk("hold_flt_fetch_addr",  64'(o_flt_fetch_addr), 64'h3);
        chk("hold_flt_decode_addr", 64'(o_flt_decode_addr), 64'h10);

        // Broadcast held back while VPU1 is not ready
        i_fwd_vpu1_rdy = 1'b0;
        push_cmd(37'h20, mk(5'h08, 3'd2, 1'b0, 1'b0, 48'hABCD), 1'b0);
        exp_fwd(2, 5'h08, 3'd2, 48'hABCD);
        cyc(5);
        chk("bcast_stall_pipes_active", 64'(o_ctl_pipes_active), 64'd1);
        chk("bcast_stall_pending",      64'(q0.size()), 64'd1);
        i_fwd_vpu1_rdy = 1'b1;
        wait_drain("bcast", 0, 50);

        // Unicast VPU1 stream then SYNC stop=1 gated by pipes_active
        i_fwd_vpu0_rdy = 1'b0;
        push_cmd(37'h30, mk(5'h10, 3'd0, 1'b1, 1'b1, 48'h10), 1'b0);
        push_cmd(37'h31, mk(5'h11, 3'd1, 1'b1, 1'b1, 48'h11), 1'b0);
        push_cmd(37'h32, mk(5'h12, 3'd7, 1'b1, 1'b1, 48'h12), 1'b0);
        push_cmd(37'h33, mk(5'h01, 3'd0, 1'b0, 1'b0, 48'h1), 1'b0);
        exp_fwd(1, 5'h10, 3'd0, 48'h10);
        exp_fwd(1, 5'h11, 3'd1, 48'h11);
        exp_fwd(1, 5'h12, 3'd7, 48'h12);
        sync_q.push_back(2'b10);
        wait_drain("uni_stream", 2, 50);
        cyc(4);
        chk("sync_gated", 64'(sync_q.size()), 64'd1);
        i_fwd_vpu0_rdy = 1'b1;
        wait_drain("sync", 0, 50);
        cyc(2);
        pulse_unhalt();

        // Halt mid-stream: only the staged command issues before unhalt
        i_fwd_vpu0_rdy = 1'b0;
        push_cmd(37'h40, mk(5'h18, 3'd1, 1'b0, 1'b0, 48'h40), 1'b0);
        push_cmd(37'h41, mk(5'h19, 3'd2, 1'b0, 1'b0, 48'h41), 1'b0);
        push_cmd(37'h42, mk(5'h1A, 3'd3, 1'b0, 1'b0, 48'h42), 1'b0);
        push_cmd(37'h43, mk(5'h1B, 3'd4, 1'b0, 1'b0, 48'h43), 1'b0);
        exp_fwd(2, 5'h18, 3'd1, 48'h40);
        cyc(3);
        i_ctl_halt = 1'b1;
        cyc(1);
        i_ctl_halt = 1'b0;
        i_fwd_vpu0_rdy = 1'b1;
        wait_drain("halt_stage", 0, 50);
        cyc(6);
        chk("halt_no_pop", 64'(fq.size()), 64'd3);
        exp_fwd(2, 5'h19, 3'd2, 48'h41);
        exp_fwd(2, 5'h1A, 3'd3, 48'h42);
        exp_fwd(2, 5'h1B, 3'd4, 48'h43);
        pulse_unhalt();
        wait_drain("halt_resume", 0, 50);
        cyc(2);
        chk("final_fifo_empty", 64'(fq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
